// File: rtl/text_ser_loader_pkg.sv
// rtl/text_ser_loader_pkg.sv - shared codes, ASCII limits, FSM states and character mapping
package text_ser_loader_pkg;

  localparam logic [6:0] SPACE       = 7'h40;
  localparam logic [6:0] SUBST       = 7'h5F;
  localparam logic [7:0] ASCII_LO    = 8'h20;
  localparam logic [7:0] ASCII_HI    = 8'h5F;
  localparam logic [7:0] LOWER_LO    = 8'h61;
  localparam logic [7:0] LOWER_HI    = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic       bad;
    logic [6:0] word;
  } map_t;

  // Raw entries carry a 6-bit column pattern; ASCII entries become {1, code-0x20}.
  function automatic map_t map_entry(input logic [7:0] data, input logic raw);
    map_t       m;
    logic [7:0] c;
    m.bad  = 1'b0;
    m.word = SUBST;
    c      = data;
    if (raw) begin
      m.word = {1'b0, data[5:0]};
    end else begin
      if (c >= LOWER_LO && c <= LOWER_HI) c = c - CASE_OFFSET;
      if (c >= ASCII_LO && c <= ASCII_HI) begin
        c      = c - ASCII_LO;
        m.word = {1'b1, c[5:0]};
      end else begin
        m.bad = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/text_ser_loader_fifo.sv
// rtl/text_ser_loader_fifo.sv - small power-of-two FIFO of display words
module text_ser_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A push into a full FIFO is legal when the same cycle frees a slot.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/text_ser_loader.sv
// rtl/text_ser_loader.sv - maps text/raw entries to 7-bit words and serialises them in 8-phase frames
module text_ser_loader
  import text_ser_loader_pkg::*;
#(
  parameter int WORD_COUNT = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_raw,
  output logic       in_ready,
  input  logic       clear,
  output logic       write,
  output logic       din,
  output logic       busy,
  output logic       err
);

  localparam int CW = $clog2(WORD_COUNT + 1);

  logic [2:0]    phase_q;
  state_e        state_q, state_d;
  logic [6:0]    word_q, word_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;
  logic          err_q, err_d;

  logic          push, pop, full, empty;
  logic [6:0]    head;
  map_t          mapped;
  logic          start, clr_active, avail_next;

  assign mapped     = map_entry(in_data, in_raw);
  assign start      = (state_q == ST_SEND) && (phase_q == 3'd0);
  assign clr_active = (clr_cnt_q != '0);
  assign pop        = start && !clr_active;
  assign in_ready   = !full || pop;
  assign push       = in_valid && in_ready;
  assign busy       = !empty || (state_q != ST_IDLE) || clr_active;
  assign err        = err_q;
  assign err_d      = err_q || (push && mapped.bad);

  always_comb begin
    clr_cnt_d = clr_cnt_q;
    if (clear)                    clr_cnt_d = CW'(WORD_COUNT);
    else if (start && clr_active) clr_cnt_d = clr_cnt_q - 1'b1;
  end

  // Decided at phase 7 so a word accepted in that cycle still starts the next frame.
  assign avail_next = (clr_cnt_d != '0) || !empty || push;

  text_ser_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(7)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .wdata  (mapped.word),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q   <= 3'd0;
      state_q   <= ST_IDLE;
      word_q    <= '0;
      clr_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      phase_q   <= phase_q + 3'd1;
      state_q   <= state_d;
      word_q    <= word_d;
      clr_cnt_q <= clr_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (phase_q == 3'd7 && avail_next) state_d = ST_SEND;
      ST_SEND: if (phase_q == 3'd6) state_d = ST_GAP;
      ST_GAP:  state_d = avail_next ? ST_SEND : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bit 0 comes straight from the selected word; later bits from the latched copy.
  always_comb begin
    write  = 1'b0;
    din    = 1'b0;
    word_d = word_q;
    if (start) word_d = clr_active ? SPACE : head;
    if (state_q == ST_SEND) begin
      write = 1'b1;
      din   = start ? word_d[0] : word_q[phase_q];
    end
  end

endmodule

// File: tb/tb_text_ser_loader.sv
// tb/tb_text_ser_loader.sv - scoreboard bench for text_ser_loader with directed and random stimulus
module tb_text_ser_loader;

  localparam int WC    = 24;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_raw;
  logic       in_ready;
  logic       clear;
  logic       write;
  logic       din;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  text_ser_loader #(
    .WORD_COUNT(WC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_raw  (in_raw),
    .in_ready(in_ready),
    .clear   (clear),
    .write   (write),
    .din     (din),
    .busy    (busy),
    .err     (err)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] exp_q[$];
  int         clr_model = 0;
  bit         err_exp   = 1'b0;
  logic [2:0] ph;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int ref_word(input int d, input bit raw);
    int c;
    if (raw) return d % 64;
    c = d;
    if (c >= 97 && c <= 122) c = c - 32;
    if (c >= 32 && c <= 95) return 64 + (c - 32);
    return 95;
  endfunction

  function automatic bit ref_bad(input int d, input bit raw);
    return !raw && (ref_word(d, raw) == 95) && (d != 8'h5F) && (d != 8'h7F - 8'h20 + 8'h20 - 8'h20 + 8'h20 ? 1'b1 : 1'b1) && !(d == 95);
  endfunction

  // Display-side phase: free-running count that restarts with reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ph <= 3'd0;
    else          ph <= ph + 3'd1;
  end

  bit in_frame = 1'b0;
  bit gap      = 1'b0;
  bit exp_start, pop_now;
  int exp_word, got_word;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame = 1'b0;
      gap      = 1'b0;
      check("rst_write", write, 0);
      check("rst_din", din, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 1);
      check("rst_err", err, 0);
    end else begin
      if (ph == 3'd0) begin
        gap       = 1'b0;
        exp_start = (exp_q.size() > 0) || (clr_model > 0);
        pop_now   = exp_start && (clr_model == 0);
        check("ready", in_ready, int'((exp_q.size() < DEPTH) || pop_now));
        check("frame_start", write, int'(exp_start));
        if (exp_start) begin
          in_frame = 1'b1;
          got_word = 0;
          if (clr_model > 0) begin
            exp_word  = 64;
            clr_model = clr_model - 1;
          end else begin
            exp_word = exp_q.pop_front();
          end
        end
      end else begin
        check("ready", in_ready, int'(exp_q.size() < DEPTH));
      end
      check("busy", busy, int'((exp_q.size() > 0) || (clr_model > 0) || in_frame || gap));
      if (in_frame) begin
        check("write_in_frame", write, 1);
        got_word = got_word | (int'(din) << ph);
        if (ph == 3'd6) begin
          check("word", got_word, exp_word);
          check("err", err, int'(err_exp));
          in_frame = 1'b0;
          gap      = 1'b1;
        end
      end else if (ph != 3'd0 || !exp_start) begin
        check("write_idle", write, 0);
        check("din_idle", din, 0);
      end
    end
  end

  // Called at posedge+1; inputs are captured by the DUT at the next posedge.
  task automatic drive(input bit v, input logic [7:0] d, input bit r, input bit c, output bit acc);
    in_valid = v;
    in_data  = d;
    in_raw   = r;
    clear    = c;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    if (acc) begin
      exp_q.push_back(7'(ref_word(int'(d), r)));
      if (!r && ref_word(int'(d), r) == 95 && d != 8'h5F) err_exp = 1'b1;
    end
    if (c) clr_model = WC;
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit a;
    for (int i = 0; i < 3000 && busy; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, a);
    check(name, busy, 0);
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    #1;
    check("rst_write_async", write, 0);
    exp_q.delete();
    clr_model = 0;
    err_exp   = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  bit acc;
  int n_acc, first_low;

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_raw   = 1'b0;
    clear    = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    drive(1'b1, 8'h41, 1'b0, 1'b0, acc);
    check("acc_A", acc, 1);
    wait_idle("idle_A");
    drive(1'b1, 8'h61, 1'b0, 1'b0, acc);
    wait_idle("idle_a");
    check("err_after_a", err, 0);
    drive(1'b1, 8'h7E, 1'b0, 1'b0, acc);
    wait_idle("idle_tilde");
    check("err_after_tilde", err, 1);
    drive(1'b1, 8'hEA, 1'b1, 1'b0, acc);
    wait_idle("idle_raw");
    check("err_sticky", err, 1);
    do_reset(2);
    check("err_cleared", err, 0);

    for (int k = 0; k < 8 && ph != 3'd7; k++) drive(1'b0, 8'h00, 1'b0, 1'b0, acc);
    n_acc     = 0;
    first_low = -1;
    for (int k = 0; k < 100 && n_acc < 6; k++) begin
      drive(1'b1, 8'(8'h42 + n_acc), 1'b0, 1'b0, acc);
      if (!acc && first_low < 0) first_low = n_acc;
      if (acc) n_acc++;
    end
    check("burst_ready_fall", first_low, 5);
    check("burst_accepted", n_acc, 6);
    drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
    repeat (20) drive(1'b0, 8'h00, 1'b0, 1'b0, acc);
    drive(1'b1, 8'h5A, 1'b0, 1'b1, acc);
    wait_idle("idle_clear");

    drive(1'b1, 8'h5A, 1'b0, 1'b0, acc);
    for (int k = 0; k < 40 && !(ph == 3'd3 && write); k++) drive(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("pre_rst_write", write, 1);
    do_reset(2);
    drive(1'b1, 8'h30, 1'b0, 1'b0, acc);
    wait_idle("idle_after_rst");

    for (int k = 0; k < 3000; k++) begin
      drive(($urandom % 3) == 0, 8'($urandom), ($urandom % 4) == 0, ($urandom % 500) == 0, acc);
    end
    for (int k = 0; k < 600; k++) begin
      drive(($urandom % 2) == 0, 8'($urandom_range(32, 127)), 1'b0, 1'b0, acc);
    end
    wait_idle("idle_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

endmodule
